// File: rtl/write_to_reg.sv
// Write-back result selector for the single-cycle RV32I core: picks the rd value
// from ALU, formatted load data, U-type immediate or link address, plus a registered copy.
module write_to_reg (
  input  logic        clk,
  input  logic        nRst,
  input  logic [5:0]  cuOP,
  input  logic [31:0] memload,
  input  logic [31:0] pc,
  input  logic [31:0] aluOut,
  input  logic [31:0] imm,
  input  logic        negative,
  output logic [31:0] writeData,
  output logic        writeEn,
  output logic [31:0] writeDataQ,
  output logic        writeEnQ
);

  localparam logic [5:0] OP_LUI   = 6'd0;
  localparam logic [5:0] OP_AUIPC = 6'd1;
  localparam logic [5:0] OP_JAL   = 6'd2;
  localparam logic [5:0] OP_JALR  = 6'd3;
  localparam logic [5:0] OP_LB    = 6'd10;
  localparam logic [5:0] OP_LH    = 6'd11;
  localparam logic [5:0] OP_LW    = 6'd12;
  localparam logic [5:0] OP_LBU   = 6'd13;
  localparam logic [5:0] OP_LHU   = 6'd14;
  localparam logic [5:0] OP_ADDI  = 6'd18;
  localparam logic [5:0] OP_SLTI  = 6'd19;
  localparam logic [5:0] OP_SLT   = 6'd31;
  localparam logic [5:0] OP_AND   = 6'd37;

  logic [31:0] w_uimm;
  logic [31:0] w_data;
  logic        w_en;
  logic [31:0] r_data_q;
  logic        r_en_q;

  assign w_uimm = {imm[31:12], 12'b0};

  always_comb begin
    w_data = aluOut;
    unique case (cuOP)
      OP_LB:           w_data = {{24{memload[7]}}, memload[7:0]};
      OP_LH:           w_data = {{16{memload[15]}}, memload[15:0]};
      OP_LW:           w_data = memload;
      OP_LBU:          w_data = {24'b0, memload[7:0]};
      OP_LHU:          w_data = {16'b0, memload[15:0]};
      OP_LUI:          w_data = w_uimm;
      OP_AUIPC:        w_data = pc + w_uimm;
      OP_JAL, OP_JALR: w_data = pc + 32'd4;
      OP_SLT, OP_SLTI: w_data = {31'b0, negative};
      default:         w_data = aluOut;
    endcase
  end

  // Branches (4..9), stores (15..17), ERROR and undefined codes never write rd.
  always_comb begin
    w_en = 1'b0;
    if (cuOP <= OP_JALR)                         w_en = 1'b1;
    else if (cuOP >= OP_LB   && cuOP <= OP_LHU)  w_en = 1'b1;
    else if (cuOP >= OP_ADDI && cuOP <= OP_AND)  w_en = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_data_q <= '0;
      r_en_q   <= 1'b0;
    end else begin
      r_data_q <= w_data;
      r_en_q   <= w_en;
    end
  end

  assign writeData  = w_data;
  assign writeEn    = w_en;
  assign writeDataQ = r_data_q;
  assign writeEnQ   = r_en_q;

endmodule

// File: tb/tb_write_to_reg.sv
// Directed-vector bench for write_to_reg: checks combinational select and the registered copy.
module tb_write_to_reg;
  logic        clk = 1'b0;
  logic        nRst;
  logic [5:0]  cuOP;
  logic [31:0] memload, pc, aluOut, imm;
  logic        negative;
  logic [31:0] writeData, writeDataQ;
  logic        writeEn, writeEnQ;

  int n_cmp = 0;
  int n_bad = 0;

  write_to_reg dut (
    .clk(clk), .nRst(nRst), .cuOP(cuOP), .memload(memload), .pc(pc),
    .aluOut(aluOut), .imm(imm), .negative(negative),
    .writeData(writeData), .writeEn(writeEn),
    .writeDataQ(writeDataQ), .writeEnQ(writeEnQ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Drive one vector mid-cycle, check comb outputs, then the registered copy after the edge.
  task automatic vec(input string tag, input logic [5:0] op, input logic [31:0] ml,
                     input logic [31:0] p, input logic [31:0] alu, input logic [31:0] im,
                     input logic neg, input logic [31:0] exp_d, input logic exp_en);
    @(negedge clk);
    cuOP = op; memload = ml; pc = p; aluOut = alu; imm = im; negative = neg;
    #1;
    chk({tag, ".d"},  writeData, exp_d);
    chk({tag, ".en"}, {31'b0, writeEn}, {31'b0, exp_en});
    @(posedge clk); #1;
    chk({tag, ".dq"},  writeDataQ, exp_d);
    chk({tag, ".enq"}, {31'b0, writeEnQ}, {31'b0, exp_en});
  endtask

  initial begin
    nRst = 1'b0; cuOP = 6'd12; memload = 32'hDEADBEEF; pc = '0; aluOut = '0; imm = '0; negative = 1'b0;
    @(posedge clk); #1;
    chk("rst.dq",  writeDataQ, 32'h0);
    chk("rst.enq", {31'b0, writeEnQ}, 32'h0);
    chk("rst.comb_d",  writeData, 32'hDEADBEEF);
    chk("rst.comb_en", {31'b0, writeEn}, 32'h1);
    nRst = 1'b1;

    //   tag       op      memload       pc            aluOut        imm           neg   data          en
    vec("LB",     6'd10, 32'hAAAAAAAA, 32'h0,        32'h11111111, 32'h0,        1'b0, 32'hFFFFFFAA, 1'b1);
    vec("LBpos",  6'd10, 32'hFFFFFF7F, 32'h0,        32'h11111111, 32'h0,        1'b0, 32'h0000007F, 1'b1);
    vec("LH",     6'd11, 32'hBBBBBABA, 32'h0,        32'h11111111, 32'h0,        1'b0, 32'hFFFFBABA, 1'b1);
    vec("LHpos",  6'd11, 32'hFFFF7FFF, 32'h0,        32'h11111111, 32'h0,        1'b0, 32'h00007FFF, 1'b1);
    vec("LW",     6'd12, 32'hABABABAB, 32'h0,        32'h11111111, 32'h0,        1'b0, 32'hABABABAB, 1'b1);
    vec("LBU",    6'd13, 32'hAAAAAAAA, 32'h0,        32'h11111111, 32'h0,        1'b0, 32'h000000AA, 1'b1);
    vec("LHU",    6'd14, 32'hBBBBBBBB, 32'h0,        32'h11111111, 32'h0,        1'b0, 32'h0000BBBB, 1'b1);
    vec("LUI0",   6'd0,  32'h0,        32'hBBBBBBBB, 32'h11111111, 32'h0000000A, 1'b0, 32'h00000000, 1'b1);
    vec("LUI1",   6'd0,  32'h0,        32'hBBBBBBBB, 32'h11111111, 32'h12345ABC, 1'b0, 32'h12345000, 1'b1);
    vec("AUIPC0", 6'd1,  32'h0,        32'hBBBBBBBB, 32'h11111111, 32'h0000000A, 1'b0, 32'hBBBBBBBB, 1'b1);
    vec("AUIPC1", 6'd1,  32'h0,        32'h00000100, 32'h11111111, 32'h12345ABC, 1'b0, 32'h12345100, 1'b1);
    vec("AUIPCw", 6'd1,  32'h0,        32'hFFFFF000, 32'h11111111, 32'h00001FFF, 1'b0, 32'h00000000, 1'b1);
    vec("JAL",    6'd2,  32'h0,        32'hBBBBBBBB, 32'h11111111, 32'h0,        1'b0, 32'hBBBBBBBF, 1'b1);
    vec("JALRw",  6'd3,  32'h0,        32'hFFFFFFFC, 32'h11111111, 32'h0,        1'b0, 32'h00000000, 1'b1);
    vec("ADD",    6'd28, 32'h0,        32'h0,        32'h00000000, 32'h0,        1'b0, 32'h00000000, 1'b1);
    vec("XOR",    6'd33, 32'h0,        32'h0,        32'hCAFEF00D, 32'h0,        1'b1, 32'hCAFEF00D, 1'b1);
    vec("SLT1",   6'd31, 32'h0,        32'h0,        32'h12345678, 32'h0,        1'b1, 32'h00000001, 1'b1);
    vec("SLTI0",  6'd19, 32'h0,        32'h0,        32'h12345678, 32'h0,        1'b0, 32'h00000000, 1'b1);
    vec("SLTU",   6'd32, 32'h0,        32'h0,        32'h00000001, 32'h0,        1'b0, 32'h00000001, 1'b1);
    vec("AND",    6'd37, 32'h0,        32'h0,        32'h0F0F0F0F, 32'h0,        1'b1, 32'h0F0F0F0F, 1'b1);
    vec("SB",     6'd15, 32'h0,        32'h0,        32'h00000000, 32'h0,        1'b0, 32'h00000000, 1'b0);
    vec("SW",     6'd17, 32'h0,        32'h0,        32'h55AA55AA, 32'h0,        1'b0, 32'h55AA55AA, 1'b0);
    vec("BEQ",    6'd4,  32'h0,        32'h0,        32'h00000001, 32'h0,        1'b1, 32'h00000001, 1'b0);
    vec("BGEU",   6'd9,  32'h0,        32'h0,        32'h00000002, 32'h0,        1'b0, 32'h00000002, 1'b0);
    vec("ERROR",  6'd38, 32'h0,        32'h0,        32'h87654321, 32'h0,        1'b0, 32'h87654321, 1'b0);
    vec("UNDEF",  6'd63, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00C0FFEE, 32'hFFFFFFFF, 1'b1, 32'h00C0FFEE, 1'b0);
    vec("LW1234", 6'd12, 32'h00001234, 32'h0,        32'h0,        32'h0,        1'b0, 32'h00001234, 1'b1);

    // Reset mid-stream: Q clears next edge, combinational path keeps selecting.
    @(negedge clk);
    nRst = 1'b0; cuOP = 6'd12; memload = 32'h00005678;
    #1;
    chk("midrst.dq_hold", writeDataQ, 32'h00001234);
    chk("midrst.comb_d",  writeData,  32'h00005678);
    @(posedge clk); #1;
    chk("midrst.dq",  writeDataQ, 32'h0);
    chk("midrst.enq", {31'b0, writeEnQ}, 32'h0);
    @(negedge clk);
    nRst = 1'b1;
    @(posedge clk); #1;
    chk("post.dq",  writeDataQ, 32'h00005678);
    chk("post.enq", {31'b0, writeEnQ}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
